// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor, one round per clock. The Caesar byte-add layer is stripped first,
// then ten inverse rounds run with round keys re-derived backwards from rk10.
module aes128_decrypt_iter #(
    parameter int CAESAR_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] cyphertext,
    output logic [127:0] plaintext,
    output logic         busy,
    output logic         done
);

    // state | meaning
    // IDLE  | waiting for start (ignored while done is high)
    // KEXP  | forward key expansion rk1..rk10, cnt 1..10
    // INIT  | strip Caesar layer, add rk10
    // ROUND | inverse rounds cnt 9..1, rk[cnt] derived backwards
    // FINAL | last round without InvMixColumns, add rk0
    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} fsm_t;

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [127:0] rk_reg;
    logic [127:0] ct_reg;
    logic [127:0] state_reg;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        return gmul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0] ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot(n3) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_caesar(input logic [127:0] ct, input logic [127:0] rk);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = ct[127-8*i -: 8] - rk[127-8*i -: 8];
        return o;
    endfunction

    logic [127:0] rk_fwd;
    logic [127:0] rk_back;
    logic [127:0] isr_isb;
    logic [127:0] ct_in;

    // rk_reg holds rk[cnt+1] during ROUND/FINAL, so the backward step uses rcon[cnt+1]
    assign rk_fwd  = key_fwd(rk_reg, rcon(cnt));
    assign rk_back = key_inv(rk_reg, rcon(cnt + 4'd1));
    assign isr_isb = inv_sub_bytes(inv_shift_rows(state_reg));
    assign ct_in   = (CAESAR_EN != 0) ? inv_caesar(ct_reg, rk_reg) : ct_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            cnt       <= 4'd0;
            rk_reg    <= '0;
            ct_reg    <= '0;
            state_reg <= '0;
            plaintext <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start && !done) begin
                        rk_reg <= key;
                        ct_reg <= cyphertext;
                        cnt    <= 4'd1;
                        busy   <= 1'b1;
                        fsm    <= KEXP;
                    end
                end
                KEXP: begin
                    rk_reg <= rk_fwd;
                    if (cnt == 4'd10) fsm <= INIT;
                    else              cnt <= cnt + 4'd1;
                end
                INIT: begin
                    state_reg <= ct_in ^ rk_reg;
                    cnt       <= 4'd9;
                    fsm       <= ROUND;
                end
                ROUND: begin
                    rk_reg    <= rk_back;
                    state_reg <= inv_mix_columns(isr_isb ^ rk_back);
                    cnt       <= cnt - 4'd1;
                    if (cnt == 4'd1) fsm <= FINAL;
                end
                FINAL: begin
                    rk_reg    <= rk_back;
                    plaintext <= isr_isb ^ rk_back;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    fsm       <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: a FIPS instance and a Caesar instance run in lockstep on the
// same plaintext expectations, fed from a reference AES-128 encryptor built into the bench.
module tb_aes128_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] ct0, ct1;
    logic [127:0] pt0, pt1;
    logic         busy0, busy1, done0, done1;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [127:0] exp_q[$];
    logic [127:0] last_pt;
    logic [7:0]   sb[256];

    always #5 clk = ~clk;

    aes128_decrypt_iter #(.CAESAR_EN(0)) u_dut_fips (
        .clk(clk), .rst(rst), .start(start), .key(key), .cyphertext(ct0),
        .plaintext(pt0), .busy(busy0), .done(done0)
    );

    aes128_decrypt_iter #(.CAESAR_EN(1)) u_dut_caesar (
        .clk(clk), .rst(rst), .start(start), .key(key), .cyphertext(ct1),
        .plaintext(pt1), .busy(busy1), .done(done1)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        logic [7:0] c, b;
        c = 8'h63;
        b = 8'h00;
        for (int i = 0; i < 8; i++)
            b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c[i];
        return b;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sb[w3[23:16]] ^ rc, sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] rk_of(input logic [127:0] k, input int n);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < n; i++) begin
            k  = key_next(k, rc);
            rc = xt(rc);
        end
        return k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3, rc;
        logic [127:0] rk, o;
        rk = k;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            rk = key_next(rk, rc);
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] caesar(input logic [127:0] c, input logic [127:0] k);
        logic [127:0] rk10, o;
        rk10 = rk_of(k, 10);
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = c[127-8*i -: 8] + rk10[127-8*i -: 8];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // scoreboard: every done pops one expected plaintext, checked on both instances
    always @(negedge clk) begin
        if (!rst && (done0 || done1)) begin
            check_val("done_sync", 128'(done1), 128'(done0));
            if (exp_q.size() == 0) begin
                check_val("stray_done", 128'(done0), 128'd0);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                check_val("pt_fips", pt0, e);
                check_val("pt_caesar", pt1, e);
                done_cnt++;
            end
        end
    end

    task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c_fips,
                        input bit scramble, input bit chk_lat);
        int n;
        bit busy_bad;
        @(negedge clk);
        start = 1'b1;
        key   = k;
        ct0   = c_fips;
        ct1   = caesar(c_fips, k);
        exp_q.push_back(p);
        @(posedge clk);
        #1;
        start    = 1'b0;
        n        = 1;
        busy_bad = 1'b0;
        while (!done0 && n < 40) begin
            if (!busy0 || !busy1) busy_bad = 1'b1;
            if (scramble) begin
                key = rnd128();
                ct0 = rnd128();
                ct1 = rnd128();
                check_val("pt_hold", pt0, last_pt);
            end
            @(posedge clk);
            #1;
            n++;
        end
        check_val("busy_held", 128'(busy_bad), 128'd0);
        if (chk_lat) check_val("latency", 128'(n), 128'd22);
        check_val("busy_at_done", 128'(busy0), 128'd0);
        last_pt = p;
        @(posedge clk);
        #1;
        check_val("done_pulse", 128'(done0), 128'd0);
    endtask

    task automatic send_rand(input logic [127:0] p, input logic [127:0] k);
        send(p, k, aes_enc(p, k), 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p, k, c;
        logic [7:0]   inv;
        int           d_before;
        logic         exp_busy;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = affine(inv);
        end

        rst = 1'b1; start = 1'b0; key = '0; ct0 = '0; ct1 = '0; last_pt = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pt_fips", pt0, 128'd0);
        check_val("rst_pt_caesar", pt1, 128'd0);
        check_val("rst_busy", {126'd0, busy1, busy0}, 128'd0);
        check_val("rst_done", {126'd0, done1, done0}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        send(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 1'b1);
        send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b1);

        send_rand({128{1'b1}}, {128{1'b1}});
        send_rand(128'd0, {128{1'b1}});
        send_rand({128{1'b1}}, 128'd0);
        for (int i = 0; i < 1000; i++) send_rand(rnd128(), rnd128());

        p = rnd128(); k = rnd128();
        send(p, k, aes_enc(p, k), 1'b1, 1'b1);
        p = rnd128(); k = rnd128();
        send(p, k, aes_enc(p, k), 1'b1, 1'b1);

        // start held high for 100 cycles: accepts at offsets 0,23,46,69,92
        d_before = done_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            exp_busy = (i == 0) ? 1'b0 : (((i - 1) % 23) <= 20);
            check_val("t4_busy", 128'(busy0), 128'(exp_busy));
            p = rnd128(); k = rnd128(); c = aes_enc(p, k);
            start = 1'b1; key = k; ct0 = c; ct1 = caesar(c, k);
            if (i % 23 == 0) exp_q.push_back(p);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check_val("t4_blocks", 128'(done_cnt - d_before), 128'd5);
        check_val("t4_q_empty", 128'(exp_q.size()), 128'd0);

        // reset during ROUND with cnt=5 (16 edges after the accepting edge's predecessor)
        @(negedge clk);
        start = 1'b1;
        key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ct0   = 128'h3925841d02dc09fbdc118597196a0b32;
        ct1   = caesar(ct0, key);
        exp_q.push_back(128'h3243f6a8885a308d313198a2e0370734);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check_val("t5_pt_fips", pt0, 128'd0);
        check_val("t5_pt_caesar", pt1, 128'd0);
        check_val("t5_busy", {126'd0, busy1, busy0}, 128'd0);
        check_val("t5_done", {126'd0, done1, done0}, 128'd0);
        repeat (3) @(negedge clk);
        check_val("t5_hold_pt", pt0 | pt1, 128'd0);
        rst = 1'b0;
        last_pt = '0;
        d_before = done_cnt;
        repeat (30) @(negedge clk);
        check_val("t5_no_done", 128'(done_cnt - d_before), 128'd0);
        send(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check_val("final_q_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
